// File: rtl/spi_frame_sequencer.sv
// Frame-level SPI register sequencer: header + data bytes staged in shadow, committed atomically at CS rise.
// Optional trailing XOR checksum byte enabled by defining CHECKSUM_EN.
module spi_frame_sequencer #(
    parameter int NREG      = 8,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              byte_rdy,
    input  logic [7:0]        byte_data,
    output logic [NREG*8-1:0] reg_q,
    output logic              update_stb,
    output logic              frame_err,
    output logic              busy
);

    // state | meaning
    // IDLE  | CS high, waiting for a frame
    // HDR   | frame open, waiting for header byte
    // DATA  | header accepted, collecting data bytes
    // ERR   | frame poisoned, ignoring bytes until CS rises
    typedef enum logic [1:0] {IDLE, HDR, DATA, ERR} state_t;

`ifdef CHECKSUM_EN
    localparam int LIMIT = MAX_BURST + 1;
`else
    localparam int LIMIT = MAX_BURST;
`endif

    state_t            state, state_nxt;
    logic              cs_prev;
    logic [NREG*8-1:0] shadow;
    logic [2:0]        addr;
    logic              inc;
    logic [8:0]        cnt;
    logic              frame_end, rx, hdr_ok, over, commit_ok;

`ifdef CHECKSUM_EN
    logic [7:0] pending;
    logic [7:0] xacc;
`endif

    function automatic logic [2:0] wrap(input int v);
        return 3'(v % NREG);
    endfunction

    assign frame_end = cs && !cs_prev;
    assign rx        = byte_rdy && !cs;
    assign hdr_ok    = (byte_data[7:4] == 4'hA);
    assign over      = rx && (state == DATA) && (cnt == 9'(LIMIT));
    assign busy      = (state != IDLE);

`ifdef CHECKSUM_EN
    assign commit_ok = (state == DATA) && (cnt >= 9'd2) && (xacc == pending);
`else
    assign commit_ok = (state == DATA) && (cnt != 9'd0);
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!cs) state_nxt = HDR;
            HDR:  if (rx) state_nxt = hdr_ok ? DATA : ERR;
            DATA: if (over) state_nxt = ERR;
            ERR:  state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
        if (frame_end && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_prev    <= 1'b1;
            reg_q      <= '0;
            shadow     <= '0;
            update_stb <= 1'b0;
            frame_err  <= 1'b0;
            addr       <= '0;
            inc        <= 1'b0;
            cnt        <= '0;
`ifdef CHECKSUM_EN
            pending    <= '0;
            xacc       <= '0;
`endif
        end else begin
            cs_prev    <= cs;
            update_stb <= 1'b0;
            frame_err  <= 1'b0;
            if (frame_end && state != IDLE) begin
                cnt <= '0;
                if (commit_ok) begin
                    reg_q      <= shadow;
                    update_stb <= 1'b1;
                end else begin
                    shadow    <= reg_q;
                    frame_err <= 1'b1;
                end
            end else if (rx) begin
                case (state)
                    HDR: if (hdr_ok) begin
                        addr <= wrap(int'(byte_data[2:0]));
                        inc  <= byte_data[3];
                        cnt  <= '0;
`ifdef CHECKSUM_EN
                        xacc <= byte_data;
`endif
                    end
                    DATA: if (!over) begin
                        cnt <= cnt + 9'd1;
`ifdef CHECKSUM_EN
                        // Previous byte is known to be data only once another byte follows it.
                        pending <= byte_data;
                        if (cnt != 9'd0) begin
                            shadow[int'(addr)*8 +: 8] <= pending;
                            xacc <= xacc ^ pending;
                            if (inc) addr <= wrap(int'(addr) + 1);
                        end
`else
                        shadow[int'(addr)*8 +: 8] <= byte_data;
                        if (inc) addr <= wrap(int'(addr) + 1);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer; expected commit/error events queued per frame, popped on pulses.
module tb_spi_frame_sequencer;

    logic        clk = 0;
    logic        reset = 1;
    logic        cs = 1;
    logic        byte_rdy = 0;
    logic [7:0]  byte_data = 0;
    logic [63:0] reg_q;
    logic        update_stb, frame_err, busy;

    spi_frame_sequencer #(.NREG(8), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset), .cs(cs), .byte_rdy(byte_rdy), .byte_data(byte_data),
        .reg_q(reg_q), .update_stb(update_stb), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {bit commit; logic [63:0] regs;} exp_t;
    exp_t        sb[$];
    logic [63:0] model_reg = '0;
    logic [63:0] prev_q = '0;
    int          total = 0;
    int          bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (update_stb || frame_err) begin
                if (sb.size() == 0) check_val("unexpected_pulse", {update_stb, frame_err}, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("pulse_kind", {update_stb, frame_err}, e.commit ? 2'b10 : 2'b01);
                    check_val("reg_q", reg_q, e.regs);
                end
            end
            if (reg_q !== prev_q && !update_stb) check_val("reg_q_hold", reg_q, prev_q);
        end
        prev_q = reg_q;
    end

    function automatic exp_t model(input logic [7:0] b[$]);
        exp_t        e;
        logic [63:0] sh;
        logic [7:0]  x;
        int          n, a;
        bit          inc_m;
        sh = model_reg;
        e.commit = 0;
        if (b.size() >= 1 && b[0][7:4] == 4'hA) begin
`ifdef CHECKSUM_EN
            n = b.size() - 2;
`else
            n = b.size() - 1;
`endif
            a = b[0][2:0];
            inc_m = b[0][3];
            x = b[0];
            if (n >= 1 && n <= 8) begin
                for (int i = 1; i <= n; i++) begin
                    sh[a*8 +: 8] = b[i];
                    x ^= b[i];
                    if (inc_m) a = (a + 1) % 8;
                end
                e.commit = 1;
`ifdef CHECKSUM_EN
                if (x != b[b.size()-1]) e.commit = 0;
`endif
            end
        end
        if (e.commit) model_reg = sh;
        e.regs = model_reg;
        return e;
    endfunction

    task automatic drive_bytes(input logic [7:0] b[$]);
        foreach (b[i]) begin
            byte_data = b[i];
            byte_rdy  = 1;
            @(posedge clk); #1;
            byte_rdy  = 0;
            @(posedge clk); #1;
        end
    endtask

    // raw=0 appends the correct checksum when the checksum build is active
    task automatic run_frame(input string tag, input logic [7:0] b_in[$], input bit raw);
        logic [7:0] b[$];
        logic [7:0] x;
        b = b_in;
`ifdef CHECKSUM_EN
        if (!raw) begin
            x = 0;
            foreach (b[i]) x ^= b[i];
            b.push_back(x);
        end
`endif
        @(posedge clk); #1;
        cs = 0;
        repeat (2) @(posedge clk);
        #1;
        drive_bytes(b);
        check_val({tag, "_busy"}, busy, 1);
        sb.push_back(model(b));
        cs = 1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check_val({tag, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_reg_q", reg_q, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_pulses", {update_stb, frame_err}, 0);
        reset = 0;
        repeat (2) @(posedge clk);

        q = '{8'hA8, 8'h11, 8'h22, 8'h33, 8'h44};                 run_frame("t1_burst", q, 0);
        q = '{8'h50, 8'h55, 8'h66};                               run_frame("t2_badhdr", q, 0);
        q = '{8'hA1, 8'h5A};                                      run_frame("t2_after", q, 0);
        q = '{8'hAE, 8'h01, 8'h02, 8'h03};                        run_frame("t3_wrap", q, 0);
        q = '{8'hA2, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99};
        run_frame("t4_over", q, 0);
        q = '{8'hAA, 8'hC1, 8'hC2};                               run_frame("t4_after", q, 0);
        q = '{8'hA8, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
        run_frame("max_burst", q, 0);
        q = '{8'hA5, 8'h0F, 8'hF0, 8'h3C};                        run_frame("fixed_addr", q, 0);
        q = '{8'hA8};                                             run_frame("hdr_only", q, 1);
        q = {};                                                   run_frame("empty", q, 1);

        // reset in the middle of a frame
        @(posedge clk); #1;
        cs = 0;
        repeat (2) @(posedge clk);
        #1;
        q = '{8'hA8, 8'hE1, 8'hE2};
        drive_bytes(q);
        reset = 1;
        cs = 1;
        repeat (2) @(posedge clk);
        #1;
        check_val("t5_reg_q", reg_q, 0);
        check_val("t5_busy", busy, 0);
        check_val("t5_pulses", {update_stb, frame_err}, 0);
        model_reg = '0;
        reset = 0;
        repeat (2) @(posedge clk);
        q = '{8'hAB, 8'h71, 8'h72};                               run_frame("t5_after", q, 0);

`ifdef CHECKSUM_EN
        q = '{8'hA8, 8'h10, 8'h20, 8'h98};                        run_frame("t6_chk_ok", q, 1);
        q = '{8'hA8, 8'h10, 8'h20, 8'h99};                        run_frame("t6_chk_bad", q, 1);
        q = '{8'hA8, 8'hA8};                                      run_frame("t6_chk_only", q, 1);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
